// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and default sizes.
package fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first asserted request at or above ptr, wrapping at NUM_REQ.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    // One extra bit so ptr+k never overflows before the explicit wrap.
    logic [IDX_W:0] sum;

    // Scan upward from ptr; the first hit wins and later hits are ignored.
    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            if (!any && req[sum[IDX_W-1:0]]) begin
                any = 1'b1;
                idx = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting bursts of up to MAX_BURST beats into one FIFO write port.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_e             state_q,     state_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [IDX_W-1:0]   grant_id_q,  grant_id_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_valid;
    logic [IDX_W-1:0]   next_ptr;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_valid = req_valid[grant_id_q];
    assign cnt_inc     = burst_cnt_q + CNT_W'(1);
    // Explicit wrap so non-power-of-two requester counts never point past the last index.
    assign next_ptr    = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

    // State, pointer, owner and beat counter registers; reset abandons any burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and decide on exit in GRANT.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d     = GRANT;
                    grant_id_d  = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!owner_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end else if (!fifo_full) begin
                    burst_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(MAX_BURST)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake and FIFO write outputs; everything is quiet outside GRANT.
    always_comb begin
        busy       = (state_q == GRANT);
        grant_id   = grant_id_q;
        req_ready  = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        if (busy) begin
            req_ready[grant_id_q] = !fifo_full;
            fifo_wr_en            = owner_valid && !fifo_full;
            fifo_din              = words[grant_id_q];
        end
    end

endmodule
